// File: rtl/sir_master.sv
// sir_master: single-transaction initiator for the Sir register bus (host command in, Sir strobes out).
// Build option: define SIR_MASTER_TIMEOUT_EN to wait up to TIMEOUT cycles for SirDack; otherwise WAIT is one cycle.
module sir_master #(
    parameter int unsigned          ADDRWIDTH = 8,
    parameter int unsigned          DATAWIDTH = 32,
    parameter int unsigned          TIMEOUT   = 16,
    parameter logic [DATAWIDTH-1:0] ERRVALUE  = {DATAWIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 HostReq,
    input  logic                 HostWr,
    input  logic [ADDRWIDTH-1:0] HostAddr,
    input  logic [DATAWIDTH-1:0] HostWdat,
    output logic                 HostBusy,
    output logic                 HostAck,
    output logic                 HostErr,
    output logic [DATAWIDTH-1:0] HostRdat,
    output logic                 SirSel,
    output logic                 SirRead,
    output logic                 SirWrite,
    output logic [ADDRWIDTH-1:0] SirAddr,
    output logic [DATAWIDTH-1:0] SirWdat,
    input  logic                 SirDack,
    input  logic [DATAWIDTH-1:0] SirRdat
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEL  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int unsigned CNTW = 8;

    logic [1:0]           state, state_nx;
    logic                 wr_q, wr_nx;
    logic                 busy_nx, ack_nx, err_nx;
    logic                 sel_nx, read_nx, write_nx;
    logic [DATAWIDTH-1:0] rdat_nx, wdat_nx;
    logic [ADDRWIDTH-1:0] addr_nx;
    logic                 expire;

`ifdef SIR_MASTER_TIMEOUT_EN
    logic [CNTW-1:0] cnt;

    // Last WAIT cycle is the one where the counter is about to reach TIMEOUT.
    assign expire = (cnt == CNTW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state != WAIT) begin
            cnt <= '0;
        end else if (cnt != CNTW'(TIMEOUT)) begin
            cnt <= cnt + CNTW'(1);
        end
    end
`else
    // Fixed one-cycle slaves: WAIT always ends after its first cycle.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expire         = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_q     <= 1'b0;
            HostBusy <= 1'b0;
            HostAck  <= 1'b0;
            HostErr  <= 1'b0;
            HostRdat <= '0;
            SirSel   <= 1'b0;
            SirRead  <= 1'b0;
            SirWrite <= 1'b0;
            SirAddr  <= '0;
            SirWdat  <= '0;
        end else begin
            state    <= state_nx;
            wr_q     <= wr_nx;
            HostBusy <= busy_nx;
            HostAck  <= ack_nx;
            HostErr  <= err_nx;
            HostRdat <= rdat_nx;
            SirSel   <= sel_nx;
            SirRead  <= read_nx;
            SirWrite <= write_nx;
            SirAddr  <= addr_nx;
            SirWdat  <= wdat_nx;
        end
    end

    // Next state and next registered outputs; strobes and host response default low.
    always_comb begin
        state_nx = state;
        wr_nx    = wr_q;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        rdat_nx  = '0;
        sel_nx   = 1'b0;
        read_nx  = 1'b0;
        write_nx = 1'b0;
        addr_nx  = SirAddr;
        wdat_nx  = SirWdat;

        case (state)
            IDLE: begin
                if (HostReq) begin
                    state_nx = SEL;
                    wr_nx    = HostWr;
                    sel_nx   = 1'b1;
                    read_nx  = ~HostWr;
                    write_nx = HostWr;
                    addr_nx  = HostAddr;
                    wdat_nx  = HostWr ? HostWdat : '0;
                end
            end
            SEL: begin
                // Any SirDack now belongs to an earlier cycle and is ignored.
                state_nx = WAIT;
            end
            WAIT: begin
                if (SirDack) begin
                    state_nx = DONE;
                    ack_nx   = 1'b1;
                    rdat_nx  = wr_q ? '0 : SirRdat;
                    addr_nx  = '0;
                    wdat_nx  = '0;
                end else if (expire) begin
                    state_nx = DONE;
                    ack_nx   = 1'b1;
                    err_nx   = 1'b1;
                    rdat_nx  = wr_q ? '0 : ERRVALUE;
                    addr_nx  = '0;
                    wdat_nx  = '0;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_sir_master.sv
// Directed self-checking bench for sir_master; expectations follow the SIR_MASTER_TIMEOUT_EN build setting.
module tb_sir_master;

    localparam logic [31:0] ERRV = 32'hBAD0_0BAD;

`ifdef SIR_MASTER_TIMEOUT_EN
    localparam int          TMO_ACK   = 18;
    localparam int          LATE_ACK  = 7;
    localparam logic [31:0] LATE_ERR  = 32'd0;
    localparam logic [31:0] LATE_RDAT = 32'h0000_CAFE;
    localparam int          INJ_CYC   = 20;
`else
    localparam int          TMO_ACK   = 3;
    localparam int          LATE_ACK  = 3;
    localparam logic [31:0] LATE_ERR  = 32'd1;
    localparam logic [31:0] LATE_RDAT = ERRV;
    localparam int          INJ_CYC   = 5;
`endif

    typedef struct packed {
        int          ack_cyc;
        int          n_ack;
        int          nsel;
        logic        err;
        logic [31:0] rdat;
        logic [2:0]  ctl1;
        logic [7:0]  addr1;
        logic [31:0] wdat1;
    } res_t;

    logic        clk;
    logic        rst;
    logic        HostReq, HostWr;
    logic [7:0]  HostAddr;
    logic [31:0] HostWdat;
    logic        HostBusy, HostAck, HostErr;
    logic [31:0] HostRdat;
    logic        SirSel, SirRead, SirWrite;
    logic [7:0]  SirAddr;
    logic [31:0] SirWdat;
    logic        SirDack;
    logic [31:0] SirRdat;

    int n_chk = 0;
    int n_bad = 0;
    int sel_cnt = 0;

    sir_master #(.ERRVALUE(ERRV)) dut (
        .clk(clk), .rst(rst),
        .HostReq(HostReq), .HostWr(HostWr), .HostAddr(HostAddr), .HostWdat(HostWdat),
        .HostBusy(HostBusy), .HostAck(HostAck), .HostErr(HostErr), .HostRdat(HostRdat),
        .SirSel(SirSel), .SirRead(SirRead), .SirWrite(SirWrite),
        .SirAddr(SirAddr), .SirWdat(SirWdat),
        .SirDack(SirDack), .SirRdat(SirRdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (SirSel) sel_cnt <= sel_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request at edge 0, then run ncyc cycles; slave acks in cycles da and db (0 = none).
    task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [31:0] wdat,
                           input int da, input int db, input logic [31:0] rd, input int ncyc,
                           output res_t r);
        r = '0;
        r.ack_cyc = -1;
        HostReq  = 1'b1;
        HostWr   = wr;
        HostAddr = addr;
        HostWdat = wdat;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            HostReq = 1'b0;
            SirDack = (c == da) || (c == db);
            SirRdat = SirDack ? rd : 32'd0;
            if (c == 1) begin
                r.ctl1  = {SirSel, SirRead, SirWrite};
                r.addr1 = SirAddr;
                r.wdat1 = SirWdat;
            end
            if (SirSel) r.nsel++;
            if (HostAck) begin
                if (r.n_ack == 0) begin
                    r.ack_cyc = c;
                    r.err     = HostErr;
                    r.rdat    = HostRdat;
                end
                r.n_ack++;
            end
        end
        SirDack = 1'b0;
        SirRdat = 32'd0;
    endtask

    initial begin
        res_t r;
        int   s0;
        int   n;

        rst = 1'b1; HostReq = 1'b0; HostWr = 1'b0; HostAddr = 8'd0; HostWdat = 32'd0;
        SirDack = 1'b0; SirRdat = 32'd0;
        tick();
        chk("rst_ctl", 32'({HostBusy, HostAck, HostErr, SirSel, SirRead, SirWrite}), 32'd0);
        chk("rst_rdat", HostRdat, 32'd0);
        chk("rst_addr", 32'(SirAddr), 32'd0);
        chk("rst_wdat", SirWdat, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Normal read
        run_txn(1'b0, 8'h01, 32'hDEAD_BEEF, 2, 0, 32'h0000_00A5, 4, r);
        chk("rd_ctl1", 32'(r.ctl1), 32'b110);
        chk("rd_addr1", 32'(r.addr1), 32'h01);
        chk("rd_wdat1", r.wdat1, 32'd0);
        chk("rd_nsel", 32'(r.nsel), 32'd1);
        chk("rd_ackcyc", 32'(r.ack_cyc), 32'd3);
        chk("rd_nack", 32'(r.n_ack), 32'd1);
        chk("rd_err", 32'(r.err), 32'd0);
        chk("rd_rdat", r.rdat, 32'h0000_00A5);
        chk("rd_after", 32'({HostBusy, HostAck, HostErr}), 32'd0);
        chk("rd_after_rdat", HostRdat, 32'd0);
        chk("rd_after_addr", 32'(SirAddr), 32'd0);

        // Normal write; slave read data must not leak back
        run_txn(1'b1, 8'h10, 32'h1234_5678, 2, 0, 32'hFFFF_FFFF, 4, r);
        chk("wr_ctl1", 32'(r.ctl1), 32'b101);
        chk("wr_addr1", 32'(r.addr1), 32'h10);
        chk("wr_wdat1", r.wdat1, 32'h1234_5678);
        chk("wr_ackcyc", 32'(r.ack_cyc), 32'd3);
        chk("wr_err", 32'(r.err), 32'd0);
        chk("wr_rdat", r.rdat, 32'd0);
        chk("wr_after_wdat", SirWdat, 32'd0);

        // Unmapped read: stale Dack in SEL, late Dack after the ack
        run_txn(1'b0, 8'h77, 32'd0, 1, INJ_CYC, 32'h5555_5555, TMO_ACK + 4, r);
        chk("tmo_ackcyc", 32'(r.ack_cyc), 32'(TMO_ACK));
        chk("tmo_nack", 32'(r.n_ack), 32'd1);
        chk("tmo_err", 32'(r.err), 32'd1);
        chk("tmo_rdat", r.rdat, ERRV);
        chk("tmo_idle", 32'({HostBusy, HostAck}), 32'd0);

        // Unmapped write returns zero data
        run_txn(1'b1, 8'h30, 32'h0BAD_F00D, 0, 0, 32'd0, TMO_ACK + 1, r);
        chk("tmow_ackcyc", 32'(r.ack_cyc), 32'(TMO_ACK));
        chk("tmow_err", 32'(r.err), 32'd1);
        chk("tmow_rdat", r.rdat, 32'd0);

        // Late slave answering in WAIT cycle 5
        run_txn(1'b0, 8'h02, 32'd0, 6, 0, 32'h0000_CAFE, 9, r);
        chk("late_ackcyc", 32'(r.ack_cyc), 32'(LATE_ACK));
        chk("late_nack", 32'(r.n_ack), 32'd1);
        chk("late_err", 32'(r.err), LATE_ERR);
        chk("late_rdat", r.rdat, LATE_RDAT);

        // Busy: requests held through cycles 1..4, only the cycle-4 one is taken
        s0 = sel_cnt;
        HostReq = 1'b1; HostWr = 1'b0; HostAddr = 8'h40;
        tick();
        HostAddr = 8'h22;
        tick();
        SirDack = 1'b1; SirRdat = 32'h0000_0011;
        tick();
        SirDack = 1'b0; SirRdat = 32'd0;
        chk("b2b_ack", 32'(HostAck), 32'd1);
        chk("b2b_rdat", HostRdat, 32'h0000_0011);
        tick();
        chk("b2b_idle", 32'(HostBusy), 32'd0);
        chk("b2b_nsel", 32'(sel_cnt - s0), 32'd1);
        tick();
        HostReq = 1'b0;
        chk("b2b_sel5", 32'(SirSel), 32'd1);
        chk("b2b_addr5", 32'(SirAddr), 32'h22);
        tick();
        SirDack = 1'b1; SirRdat = 32'h0000_0022;
        tick();
        SirDack = 1'b0; SirRdat = 32'd0;
        chk("b2b_ack2", 32'(HostAck), 32'd1);
        chk("b2b_rdat2", HostRdat, 32'h0000_0022);
        tick();

        // Reset asserted mid-WAIT while the slave answers
        HostReq = 1'b1; HostWr = 1'b0; HostAddr = 8'h05;
        tick();
        HostReq = 1'b0;
        tick();
        SirDack = 1'b1; SirRdat = 32'h0000_0077;
        #2 rst = 1'b1;
        #1;
        chk("mrst_ctl", 32'({HostBusy, HostAck, HostErr, SirSel, SirRead, SirWrite}), 32'd0);
        chk("mrst_addr", 32'(SirAddr), 32'd0);
        tick();
        SirDack = 1'b0; SirRdat = 32'd0;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (HostAck) n++;
            tick();
        end
        chk("mrst_noack", 32'(n), 32'd0);
        chk("mrst_idle", 32'(HostBusy), 32'd0);

        run_txn(1'b0, 8'h01, 32'd0, 2, 0, 32'h0000_00A5, 4, r);
        chk("post_ackcyc", 32'(r.ack_cyc), 32'd3);
        chk("post_rdat", r.rdat, 32'h0000_00A5);
        chk("post_err", 32'(r.err), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
